// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// request record, the control state enum, and the little-endian lane helpers
// used for sub-word loads (extract + extend) and sub-word stores (merge).
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_TRIGGER,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_MERGE,
      ST_RESP
   } state_e;

   // Size 11 is reserved and always faults; halves need an even address,
   // words a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         SIZE_WORD: bad = (lane != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Pull the addressed byte/half out of a RAM word and extend it.
   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sign_ext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: r = {{24{sign_ext & b[7]}}, b};
         SIZE_HALF: r = {{16{sign_ext & h[15]}}, h};
         default:   r = word;
      endcase
      return r;
   endfunction

   // Insert the right-justified store data into the addressed lane of the
   // word read back from RAM; the other lanes are preserved.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      case (size)
         SIZE_BYTE: begin
            case (lane)
               2'd0:    r[7:0]   = data[7:0];
               2'd1:    r[15:8]  = data[7:0];
               2'd2:    r[23:16] = data[7:0];
               default: r[31:24] = data[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (lane[1]) r[31:16] = data[15:0];
            else         r[15:0]  = data[15:0];
         end
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_access_unit_ready_sync.sv
// ---------------------------------------------------------------------------
// mem_access_unit_ready_sync
// STAGES-deep flop chain bringing the RAM's asynchronous ready level into
// the clock domain. Resets to 1, the RAM's idle (ready) level.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : raw ready level from the RAM
//   sync_out   : synchronised ready (STAGES >= 2)
// ---------------------------------------------------------------------------
module mem_access_unit_ready_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= sync_d;
   end

   assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store stage in front of a word-wide RAM with a toggle-trigger /
// ready-level handshake. Handles byte/half loads (zero/sign extend) and
// byte/half stores by read-modify-write, one request at a time.
//   clkIn, resetNIn            : clock, asynchronous active-low reset
//   req*  (Valid/Ready/Write/Size/Signed/Addr/Data) : request from execute
//   resp* (Valid/Ready/Data/Fault/Timeout)          : one response per request
//   mem*  (Addr/Data/Rw/Trigger out, Data/Ready in) : RAM interface
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clkIn,
   input  logic        resetNIn,
   input  logic        reqValidIn,
   output logic        reqReadyOut,
   input  logic        reqWriteIn,
   input  logic [1:0]  reqSizeIn,
   input  logic        reqSignedIn,
   input  logic [31:0] reqAddrIn,
   input  logic [31:0] reqDataIn,
   output logic        respValidOut,
   input  logic        respReadyIn,
   output logic [31:0] respDataOut,
   output logic        respFaultOut,
   output logic        respTimeoutOut,
   output logic [31:0] memAddrOut,
   output logic [31:0] memDataOut,
   output logic        memRwOut,
   output logic        memTriggerOut,
   input  logic [31:0] memDataIn,
   input  logic        memReadyIn
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic ready_sync;

   mem_access_unit_ready_sync #(.STAGES(SYNC_STAGES)) u_ready_sync (
      .clk      (clkIn),
      .rst_n    (resetNIn),
      .async_in (memReadyIn),
      .sync_out (ready_sync)
   );

   state_e             state_q,        state_d;
   req_t               req_q,          req_d;
   logic               req_ready_q,    req_ready_d;
   logic               write_pass_q,   write_pass_d;
   logic [31:0]        word_q,         word_d;
   logic [CNT_W-1:0]   cnt_q,          cnt_d;
   logic               resp_valid_q,   resp_valid_d;
   logic [31:0]        resp_data_q,    resp_data_d;
   logic               resp_fault_q,   resp_fault_d;
   logic               resp_timeout_q, resp_timeout_d;
   logic [29:0]        mem_addr_q,     mem_addr_d;
   logic [31:0]        mem_data_q,     mem_data_d;
   logic               mem_rw_q,       mem_rw_d;
   logic               mem_trigger_q,  mem_trigger_d;

   logic sub_word_store;
   assign sub_word_store = req_q.write && (req_q.size != SIZE_WORD);

   // NOTE: every signal assigned below gets a hold-value default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      req_ready_d    = req_ready_q;
      write_pass_d   = write_pass_q;
      word_d         = word_q;
      cnt_d          = cnt_q;
      resp_valid_d   = resp_valid_q;
      resp_data_d    = resp_data_q;
      resp_fault_d   = resp_fault_q;
      resp_timeout_d = resp_timeout_q;
      mem_addr_d     = mem_addr_q;
      mem_data_d     = mem_data_q;
      mem_rw_d       = mem_rw_q;
      mem_trigger_d  = mem_trigger_q;

      case (state_q)
         ST_IDLE: begin
            if (reqValidIn && req_ready_q) begin
               req_d          = '{write: reqWriteIn, size: reqSizeIn, sgn: reqSignedIn,
                                  addr: reqAddrIn, data: reqDataIn};
               req_ready_d    = 1'b0;
               write_pass_d   = 1'b0;
               resp_data_d    = '0;
               resp_timeout_d = 1'b0;
               if (is_misaligned(reqSizeIn, reqAddrIn[1:0])) begin
                  // Fault skips the RAM entirely.
                  resp_fault_d = 1'b1;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  resp_fault_d = 1'b0;
                  state_d      = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            // Address/data/rw settle a full cycle before the trigger edge.
            // On the write pass of a sub-word store, MERGE already set data/rw.
            mem_addr_d = req_q.addr[31:2];
            if (!write_pass_q) begin
               mem_data_d = req_q.data;
               mem_rw_d   = req_q.write && (req_q.size == SIZE_WORD);
            end
            state_d = ST_TRIGGER;
         end
         ST_TRIGGER: begin
            mem_trigger_d = ~mem_trigger_q;
            cnt_d         = '0;
            state_d       = ST_WAIT_LO;
         end
         ST_WAIT_LO, ST_WAIT_HI: begin
            if (ready_sync == (state_q == ST_WAIT_HI)) begin
               cnt_d = '0;
               if (state_q == ST_WAIT_LO) begin
                  state_d = ST_WAIT_HI;
               end else if (!req_q.write) begin
                  resp_data_d  = lane_extract(memDataIn, req_q.size, req_q.addr[1:0], req_q.sgn);
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else if (sub_word_store && !write_pass_q) begin
                  word_d  = memDataIn;
                  state_d = ST_MERGE;
               end else begin
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abort without re-toggling: the trigger keeps its parity so it
               // still matches the RAM once the RAM finishes on its own.
               resp_timeout_d = 1'b1;
               resp_data_d    = '0;
               resp_valid_d   = 1'b1;
               state_d        = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MERGE: begin
            mem_data_d   = lane_merge(word_q, req_q.data, req_q.size, req_q.addr[1:0]);
            mem_rw_d     = 1'b1;
            write_pass_d = 1'b1;
            state_d      = ST_SETUP;
         end
         ST_RESP: begin
            if (respReadyIn) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkIn or negedge resetNIn) begin
      if (!resetNIn) begin
         state_q        <= ST_IDLE;
         req_q          <= '0;
         req_ready_q    <= 1'b1;
         write_pass_q   <= 1'b0;
         word_q         <= '0;
         cnt_q          <= '0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_fault_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         mem_rw_q       <= 1'b0;
         mem_trigger_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         req_ready_q    <= req_ready_d;
         write_pass_q   <= write_pass_d;
         word_q         <= word_d;
         cnt_q          <= cnt_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_fault_q   <= resp_fault_d;
         resp_timeout_q <= resp_timeout_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_q     <= mem_data_d;
         mem_rw_q       <= mem_rw_d;
         mem_trigger_q  <= mem_trigger_d;
      end
   end

   assign reqReadyOut    = req_ready_q;
   assign respValidOut   = resp_valid_q;
   assign respDataOut    = resp_data_q;
   assign respFaultOut   = resp_fault_q;
   assign respTimeoutOut = resp_timeout_q;
   assign memAddrOut     = {2'b00, mem_addr_q};
   assign memDataOut     = mem_data_q;
   assign memRwOut       = mem_rw_q;
   assign memTriggerOut  = mem_trigger_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly upstream of the word-wide RAM. Accepts one clocked load/store request at a time from the execute stage and translates it into the RAM's toggle-trigger / ready-level protocol.
- Performs ARM sub-word handling: byte/halfword loads with sign or zero extension, and byte/halfword stores by read-modify-write, because the RAM has no byte enables.
- Returns one response per request, carrying data, an alignment fault or a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: clkIn cycles allowed per RAM phase (wait-low or wait-high) before abort.
- SYNC_STAGES, 2: flip-flop depth of the memReadyIn synchroniser, minimum 2.

Ports:
- clkIn  input  1  single clock.
- resetNIn  input  1  asynchronous, active-low reset.
- reqValidIn  input  1  request present.
- reqReadyOut  output  1  unit can accept a request.
- reqWriteIn  input  1  1 = store, 0 = load.
- reqSizeIn  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- reqSignedIn  input  1  sign-extend a sub-word load.
- reqAddrIn  input  32  byte address.
- reqDataIn  input  32  store data, right-justified.
- respValidOut  output  1  response held until consumed.
- respReadyIn  input  1  consumer accepts the response.
- respDataOut  output  32  load result; 0 for stores.
- respFaultOut  output  1  misaligned address or size 11.
- respTimeoutOut  output  1  RAM did not complete in time.
- memAddrOut  output  32  word address, equal to reqAddr[31:2] zero-extended.
- memDataOut  output  32  write data to the RAM.
- memRwOut  output  1  1 = write.
- memTriggerOut  output  1  toggles once per RAM transaction.
- memDataIn  input  32  RAM read data.
- memReadyIn  input  1  asynchronous RAM ready level.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE, reqReadyOut=1, respValidOut=0.
  - All mem* outputs 0, including memTriggerOut.
  - resp data and flags 0, timeout counter 0.
- RAM contract:
  - The RAM drops ready after seeing a trigger toggle and holds it low for at least SYNC_STAGES+1 clkIn periods.
  - It raises ready when the access is complete; read data is valid while ready is high.
  - memAddrOut, memDataOut and memRwOut are registered one cycle before the toggle. They stay stable until the synchronised ready is seen high.
- Acceptance: a request is accepted when reqValidIn && reqReadyOut; the unit captures it and reqReadyOut falls the next cycle.
- Alignment check at accept:
  - Fault if size 11, or size 01 with addr[0]=1, or size 10 with addr[1:0]!=0.
  - A fault goes directly to RESP with respFaultOut=1, data 0 and no RAM access.
- States:
  - IDLE: wait for acceptance.
  - SETUP: drive addr; memRwOut = 1 only for a word store; memDataOut = reqData. Next cycle, toggle the trigger.
  - WAIT_LO: wait for synchronised ready = 0.
  - WAIT_HI: wait for synchronised ready = 1, then capture memDataIn.
  - MERGE (sub-word store only): insert the byte or half into the captured word at lane addr[1:0] (little-endian). Set memRwOut=1, then SETUP again for the write pass.
  - RESP: hold the response until respReadyIn, then IDLE with reqReadyOut=1 in the same cycle.
- Load result:
  - Extract byte lane addr[1:0] or half lane addr[1].
  - Zero- or sign-extend per reqSignedIn. Word loads ignore reqSignedIn.
- Transaction counts:
  - Word store or any load: 1 RAM transaction.
  - Sub-word store: 2 transactions, a read then a write.
- Latency: minimum accept-to-respValidOut for a word load is SETUP(1) + toggle(1) + WAIT_LO(≥SYNC_STAGES+1) + WAIT_HI(≥SYNC_STAGES) + 1.
- Timeout:
  - The counter clears on entry to each WAIT state. Reaching TIMEOUT_CYCLES goes to RESP with respTimeoutOut=1 and data 0.
  - memTriggerOut is not toggled again. It keeps its parity, so it remains consistent with the RAM once the RAM finishes.
- A response waiting in RESP ignores reqValidIn (reqReadyOut=0). respValidOut and respReadyIn high together in RESP complete the handshake in one cycle.
- Reset mid-transaction:
  - All state returns to reset values and memTriggerOut returns to 0.
  - The RAM must also be reset. No resumption is attempted.

Decomposition:
- Shared package: size encodings (SIZE_BYTE/HALF/WORD), state enum, lane-extract and lane-merge functions.
- One natural sub-module, ready_sync: a SYNC_STAGES-deep flop chain with the same async active-low reset, resetting to 1 (idle ready).

Test Plan:
- Word store 0x0000001F to byte addr 0x8, then word load from 0x8 → exactly one trigger toggle each; memAddrOut=2; load returns 0x0000001F with no flags.
- RAM word at addr 2 preset to 0x11223344; store byte 0xAB to 0x9 → read then write toggles, written word 0x1122AB44; reqReadyOut stays low throughout.
- Word 0x80FF7F01 at addr 0: LDRSB @0x1 → 0x0000007F; LDRSB @0x2 → 0xFFFFFFFF; LDRH @0x2 → 0x000080FF; LDRSH @0x2 → 0xFFFF80FF.
- Halfword load @0x3 and word store @0x2 → respFaultOut=1 one cycle after accept; memTriggerOut unchanged.
- RAM model never raises ready, TIMEOUT_CYCLES=16 → respTimeoutOut=1 after 16 WAIT_HI cycles; the next request is accepted after respReadyIn.
- resetNIn pulsed low during WAIT_LO → all outputs return to reset values immediately, without waiting for a clock edge; a subsequent word load completes normally.
